// File: rtl/mem_stage_if.sv
// mem_stage_if: AGEX -> MEM -> WB/DE latch bundle for the memory stage.
// Also holds the latch-width and opcode defines shared by the stage and its users.
// MEM_FWD_EN widens from_MEM_to_DE to carry wb_val for DE-side bypassing.
`ifndef MEM_STAGE_IF_DEFS
`define MEM_STAGE_IF_DEFS
`define OP_I_WIDTH 8
`define NOP_I 8'd0
`define ADD_I 8'd1
`define LW_I 8'd2
`define SW_I 8'd3
// inst, PC, op_I, inst_count, reg_dest, result, wr_reg, mem_addr, bus_canary
`define AGEX_latch_WIDTH 206
// inst, PC, op_I, inst_count, reg_dest, wb_val, wr_reg, bus_canary
`define MEM_latch_WIDTH 174
`define from_MEM_to_AGEX_WIDTH 1
`ifdef MEM_FWD_EN
`define from_MEM_to_DE_WIDTH 38
`else
`define from_MEM_to_DE_WIDTH 6
`endif
`endif

interface mem_stage_if;
    logic [`AGEX_latch_WIDTH-1:0]      from_AGEX_latch;
    logic [`MEM_latch_WIDTH-1:0]       MEM_latch_out;
    logic [`from_MEM_to_AGEX_WIDTH-1:0] from_MEM_to_AGEX;
    logic [`from_MEM_to_DE_WIDTH-1:0]  from_MEM_to_DE;

    // pipeline side driving the stage (AGEX in, MEM/DE/stall consumed)
    modport master (
        output from_AGEX_latch,
        input  MEM_latch_out,
        input  from_MEM_to_AGEX,
        input  from_MEM_to_DE
    );

    // the memory stage itself
    modport slave (
        input  from_AGEX_latch,
        output MEM_latch_out,
        output from_MEM_to_AGEX,
        output from_MEM_to_DE
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage between AGEX and WB.
// Word stores/loads against a private data memory; loads take LOAD_LAT cycles
// and stall AGEX for LOAD_LAT-1 of them. Optional macro MEM_FWD_EN adds wb_val
// to the DE report so DE can bypass instead of stalling.
module mem_stage #(
    parameter int DMEM_WORDS = 1024,
    parameter int LOAD_LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave mem_bus
);
    localparam int IDX_W = $clog2(DMEM_WORDS);
    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_LOAD_WAIT = 1'b1;

    // AGEX latch fields
    logic [31:0]            w_inst;
    logic [31:0]            w_pc;
    logic [`OP_I_WIDTH-1:0] w_op;
    logic [31:0]            w_icount;
    logic [4:0]             w_rd;
    logic [31:0]            w_result;
    logic                   w_wr_reg;
    logic [31:0]            w_addr;
    logic [31:0]            w_canary;

    logic [IDX_W-1:0]              w_idx;
    logic [31:0]                   w_rdata;
    logic                          w_is_lw;
    logic                          w_is_sw;
    logic                          w_stall;
    logic                          w_mem_we;
    logic [31:0]                   w_wb_val;
    logic                          w_wr_eff;
    logic [`MEM_latch_WIDTH-1:0]   w_latch_next;
    logic                          w_unused;

    logic [31:0]                   r_mem [DMEM_WORDS];
    logic [0:0]                    r_state;
    logic [3:0]                    r_cnt;
    logic [`MEM_latch_WIDTH-1:0]   r_latch;

    assign {w_inst, w_pc, w_op, w_icount, w_rd, w_result, w_wr_reg, w_addr, w_canary} =
        mem_bus.from_AGEX_latch;

    // byte offset and high address bits are dropped, so addresses wrap
    assign w_idx    = w_addr[IDX_W+1:2];
    assign w_unused = ^{w_addr[31:IDX_W+2], w_addr[1:0]};

    assign w_is_lw  = (w_op == `LW_I);
    assign w_is_sw  = (w_op == `SW_I);
    assign w_rdata  = r_mem[w_idx];
    assign w_wb_val = w_is_lw ? w_rdata : w_result;
    assign w_wr_eff = w_is_sw ? 1'b0 : w_wr_reg;

    assign w_latch_next = {w_inst, w_pc, w_op, w_icount, w_rd, w_wb_val, w_wr_eff, w_canary};

    // a store only commits while idle, so it can never coincide with a stall
    assign w_mem_we = (r_state == S_IDLE) && w_is_sw && !reset;

    // stall AGEX while a load still has wait cycles left
    always_comb begin
        w_stall = 1'b0;
        if (r_state == S_IDLE)
            w_stall = w_is_lw && (LOAD_LAT > 1);
        else
            w_stall = (r_cnt != 4'd0);
    end

    // data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_idx] <= w_result;
    end

    // load-wait FSM and MEM latch; bubbles fill the latch during a wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_latch <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_is_lw && (LOAD_LAT > 1)) begin
                r_state <= S_LOAD_WAIT;
                r_cnt   <= 4'(LOAD_LAT - 2);
                r_latch <= '0;
            end else begin
                r_latch <= w_latch_next;
            end
        end else begin
            if (r_cnt != 4'd0) begin
                r_cnt   <= r_cnt - 4'd1;
                r_latch <= '0;
            end else begin
                // AGEX held the LW, so the computed contents are the load result
                r_latch <= w_latch_next;
                r_state <= S_IDLE;
            end
        end
    end

    assign mem_bus.MEM_latch_out    = r_latch;
    assign mem_bus.from_MEM_to_AGEX = w_stall;
`ifdef MEM_FWD_EN
    assign mem_bus.from_MEM_to_DE   = {r_latch[69:65], r_latch[32], r_latch[64:33]};
`else
    assign mem_bus.from_MEM_to_DE   = {r_latch[69:65], r_latch[32]};
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: three mem_stage instances (LOAD_LAT 1, 3, 4) driven by directed
// vectors, checked every cycle against an occupancy-based behavioural model.
module tb_mem_stage;
    localparam int DEW = `from_MEM_to_DE_WIDTH;
    localparam int LATS [3] = '{1, 3, 4};

    logic clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [205:0] agex [3];
    logic [173:0] lat_w [3];
    logic [2:0]   stall_w;
    logic [DEW-1:0] de_w [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int seq = 0;

    // behavioural model state
    logic [173:0] exp_lat [3];
    int age [3];
    logic [31:0] mm [int];

    always #5 clk = ~clk;

    mem_stage_if if0 ();
    mem_stage_if if1 ();
    mem_stage_if if2 ();

    assign if0.from_AGEX_latch = agex[0];
    assign if1.from_AGEX_latch = agex[1];
    assign if2.from_AGEX_latch = agex[2];
    assign lat_w[0] = if0.MEM_latch_out;
    assign lat_w[1] = if1.MEM_latch_out;
    assign lat_w[2] = if2.MEM_latch_out;
    assign stall_w  = {if2.from_MEM_to_AGEX, if1.from_MEM_to_AGEX, if0.from_MEM_to_AGEX};
    assign de_w[0]  = if0.from_MEM_to_DE;
    assign de_w[1]  = if1.from_MEM_to_DE;
    assign de_w[2]  = if2.from_MEM_to_DE;

    mem_stage #(.DMEM_WORDS(1024), .LOAD_LAT(1)) u0 (.clk(clk), .reset(rst[0]), .mem_bus(if0.slave));
    mem_stage #(.DMEM_WORDS(1024), .LOAD_LAT(3)) u1 (.clk(clk), .reset(rst[1]), .mem_bus(if1.slave));
    mem_stage #(.DMEM_WORDS(1024), .LOAD_LAT(4)) u2 (.clk(clk), .reset(rst[2]), .mem_bus(if2.slave));

    task automatic chk(input string nm, input logic [205:0] act, input logic [205:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [205:0] mk(input logic [7:0] op, input logic [4:0] rd,
                                        input logic [31:0] res, input logic wr,
                                        input logic [31:0] addr);
        seq++;
        return {32'hA5A5_0000 | 32'(seq), 32'h0000_1000 + 32'(seq * 4), op, 32'(seq),
                rd, res, wr, addr, 32'hC0DE_0000 | 32'(seq)};
    endfunction

    function automatic int midx(input int k, input logic [31:0] addr);
        return k * 4096 + int'((addr >> 2) & 32'd1023);
    endfunction

    // a LW occupies the stage for LATS cycles; all but the last one stall
    function automatic logic m_stall(input int k);
        return (agex[k][141:134] == `LW_I) && (age[k] < LATS[k] - 1);
    endfunction

    function automatic logic [173:0] m_out(input int k);
        logic [31:0] inst, pc, ic, res, addr, can;
        logic [7:0] op;
        logic [4:0] dst;
        logic wr;
        {inst, pc, op, ic, dst, res, wr, addr, can} = agex[k];
        if (op == `LW_I) res = mm.exists(midx(k, addr)) ? mm[midx(k, addr)] : 32'h0;
        if (op == `SW_I) wr = 1'b0;
        return {inst, pc, op, ic, dst, res, wr, can};
    endfunction

    function automatic logic [DEW-1:0] m_de(input logic [173:0] l);
`ifdef MEM_FWD_EN
        return {l[69:65], l[32], l[64:33]};
`else
        return {l[69:65], l[32]};
`endif
    endfunction

    // model advance at each edge
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                exp_lat[k] = '0;
                age[k] = 0;
            end else if (m_stall(k)) begin
                exp_lat[k] = '0;
                age[k]++;
            end else begin
                exp_lat[k] = m_out(k);
                age[k] = 0;
                if (agex[k][141:134] == `SW_I) mm[midx(k, agex[k][63:32])] = agex[k][96:65];
            end
        end
    end

    // compare DUT against model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("latch%0d", k), 206'(lat_w[k]), 206'(exp_lat[k]));
                chk($sformatf("stall%0d", k), 206'(stall_w[k]), 206'(m_stall(k)));
                chk($sformatf("de%0d", k), 206'(de_w[k]), 206'(m_de(exp_lat[k])));
            end
        end
    end

    // hold w until accepted (edge where stall was low); ns = stall cycles seen
    task automatic send(input int k, input logic [205:0] w, output int ns);
        int n;
        logic s;
        n = 0;
        ns = 0;
        agex[k] = w;
        do begin
            @(negedge clk);
            s = stall_w[k];
            if (s) ns++;
            @(posedge clk);
            #1;
            n++;
        end while (s && n < 40);
        if (s) chk($sformatf("send_timeout%0d", k), 206'(1), 206'(0));
        agex[k] = '0;
    endtask

    initial begin
        int ns;
        for (int k = 0; k < 3; k++) begin
            agex[k] = mk(`ADD_I, 5'd3, 32'h5555, 1'b1, 32'h0);
            exp_lat[k] = '0;
            age[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_latch%0d", k), 206'(lat_w[k]), 206'(0));
            chk($sformatf("rst_stall%0d", k), 206'(stall_w[k]), 206'(0));
            chk($sformatf("rst_de%0d", k), 206'(de_w[k]), 206'(0));
            agex[k] = '0;
        end
        rst = 3'b000;
        chk_en = 1'b1;

        // ALU pass-through, 1-cycle latency
        send(0, mk(`ADD_I, 5'd5, 32'h1234, 1'b1, 32'h0), ns);
        chk("add_wb", 206'(lat_w[0][64:33]), 206'(32'h1234));
        chk("add_wr", 206'(lat_w[0][32]), 206'(1));
        chk("add_de", 206'(de_w[0][DEW-1 -: 6]), 206'(6'b00101_1));
        chk("add_nostall", 206'(ns), 206'(0));

        // store then load, LOAD_LAT=1
        send(0, mk(`SW_I, 5'd4, 32'hDEAD_BEEF, 1'b1, 32'h40), ns);
        chk("sw_wr0", 206'(lat_w[0][32]), 206'(0));
        send(0, mk(`LW_I, 5'd7, 32'h0, 1'b1, 32'h40), ns);
        chk("lw1_wb", 206'(lat_w[0][64:33]), 206'(32'hDEAD_BEEF));
        chk("lw1_nostall", 206'(ns), 206'(0));

        // address wrap
        send(0, mk(`SW_I, 5'd0, 32'd9, 1'b0, 32'h1000), ns);
        send(0, mk(`LW_I, 5'd8, 32'h0, 1'b1, 32'h0), ns);
        chk("wrap_wb", 206'(lat_w[0][64:33]), 206'(32'd9));

        // LOAD_LAT=3, misaligned address ignores low bits
        send(1, mk(`SW_I, 5'd0, 32'd7, 1'b0, 32'h40), ns);
        send(1, mk(`LW_I, 5'd9, 32'h0, 1'b1, 32'h43), ns);
        chk("lw3_stalls", 206'(ns), 206'(2));
        chk("lw3_wb", 206'(lat_w[1][64:33]), 206'(32'd7));
        send(1, mk(`ADD_I, 5'd2, 32'hABCD, 1'b1, 32'h0), ns);
        chk("lw3_idle_after", 206'(ns), 206'(0));
        chk("lw3_add_wb", 206'(lat_w[1][64:33]), 206'(32'hABCD));

        // back-to-back loads, second through a wrapped address
        send(1, mk(`SW_I, 5'd0, 32'h55, 1'b0, 32'h80), ns);
        send(1, mk(`LW_I, 5'd10, 32'h0, 1'b1, 32'h80), ns);
        chk("b2b_first_wb", 206'(lat_w[1][64:33]), 206'(32'h55));
        send(1, mk(`LW_I, 5'd11, 32'h0, 1'b1, 32'h1040), ns);
        chk("b2b_second_stalls", 206'(ns), 206'(2));
        chk("b2b_second_wb", 206'(lat_w[1][64:33]), 206'(32'd7));

        // LOAD_LAT=4, reset on the first wait cycle
        send(2, mk(`SW_I, 5'd0, 32'h77, 1'b0, 32'h100), ns);
        agex[2] = mk(`LW_I, 5'd12, 32'h0, 1'b1, 32'h100);
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        agex[2] = '0;
        #1;
        chk("rstw_stall", 206'(stall_w[2]), 206'(0));
        chk("rstw_latch", 206'(lat_w[2]), 206'(0));
        send(2, mk(`ADD_I, 5'd13, 32'h4242, 1'b1, 32'h0), ns);
        chk("rstw_add_ns", 206'(ns), 206'(0));
        chk("rstw_add_wb", 206'(lat_w[2][64:33]), 206'(32'h4242));
        send(2, mk(`LW_I, 5'd14, 32'h0, 1'b1, 32'h100), ns);
        chk("lw4_stalls", 206'(ns), 206'(3));
        chk("lw4_mem_kept", 206'(lat_w[2][64:33]), 206'(32'h77));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
